// File: rtl/mips_alu_if.sv
// mips_alu_if: operand/result bundle for mips_alu; ALU_FLAGS_EN adds Carry/Overflow/Negative.
interface mips_alu_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic [WIDTH-1:0] ALUResult_q;
    logic             Zero_q;
`ifdef ALU_FLAGS_EN
    logic             Carry;
    logic             Overflow;
    logic             Negative;
`endif

    modport master (
        output A, B, ALUControl,
        input  ALUResult, Zero, ALUResult_q, Zero_q
`ifdef ALU_FLAGS_EN
        , input Carry, Overflow, Negative
`endif
    );

    modport slave (
        input  A, B, ALUControl,
        output ALUResult, Zero, ALUResult_q, Zero_q
`ifdef ALU_FLAGS_EN
        , output Carry, Overflow, Negative
`endif
    );
endinterface

// File: rtl/mips_alu.sv
// mips_alu: 14-op combinational MIPS ALU with zero flag and registered copies.
// Define ALU_FLAGS_EN to add combinational Carry/Overflow/Negative outputs.
module mips_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input logic clk,
    input logic rst,
    mips_alu_if.slave bus
);
    logic [WIDTH-1:0]   a, b, res;
    logic [3:0]         op;
    logic [SHAMT_W-1:0] sh;
    logic [2*WIDTH-1:0] rol_w, ror_w;

    assign a  = bus.A;
    assign b  = bus.B;
    assign op = bus.ALUControl;
    assign sh = b[SHAMT_W-1:0];

`ifdef ALU_FLAGS_EN
    logic [WIDTH:0] sum, dif;
    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};
`else
    logic [WIDTH-1:0] sum, dif;
    assign sum = a + b;
    assign dif = a - b;
`endif

    // Rotates shift a doubled copy so the wrapped bits fall into the kept half.
    assign rol_w = {a, a} << sh;
    assign ror_w = {a, a} >> sh;

    always_comb begin
        res = '0;
        case (op)
            4'b0000: res = sum[WIDTH-1:0];
            4'b0001: res = dif[WIDTH-1:0];
            4'b0010: res = a * b;
            4'b0011: res = a & b;
            4'b0100: res = a ^ b;
            4'b0101: res = a | b;
            4'b0110: res = ~a;
            4'b0111: res = '0 - a;
            4'b1000: res = a << sh;
            4'b1001: res = a >> sh;
            4'b1010: res = a << sh;
            4'b1011: res = $unsigned($signed(a) >>> sh);
            4'b1100: res = rol_w[2*WIDTH-1:WIDTH];
            4'b1101: res = ror_w[WIDTH-1:0];
            default: res = '0;
        endcase
    end

    assign bus.ALUResult = res;
    assign bus.Zero      = ~|res;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ALUResult_q <= '0;
            bus.Zero_q      <= 1'b0;
        end else begin
            bus.ALUResult_q <= res;
            bus.Zero_q      <= ~|res;
        end
    end

`ifdef ALU_FLAGS_EN
    logic ovf_add, ovf_sub;
    assign ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
    // The borrow out of the widened subtract is exactly unsigned A<B.
    assign bus.Carry    = (op == 4'b0000) ? sum[WIDTH] :
                          (op == 4'b0001) ? dif[WIDTH] : 1'b0;
    assign bus.Overflow = (op == 4'b0000) ? ovf_add :
                          (op == 4'b0001) ? ovf_sub :
                          (op == 4'b0111) ? (a == {1'b1, {(WIDTH-1){1'b0}}}) : 1'b0;
    assign bus.Negative = res[WIDTH-1];
`endif
endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: directed vectors with a scoreboard queue checked by a separate monitor.
module tb_mips_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    mips_alu_if #(.WIDTH(32)) bus ();
    mips_alu #(.WIDTH(32), .SHAMT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        z;
        logic [31:0] q;
        logic        zq;
        logic        c;
        logic        v;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_res = '0;
    logic        last_z   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Inputs change just after a posedge; the registered outputs then show what
    // the previous vector (or reset) loaded at that edge.
    task automatic apply(input logic r, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res,
                         input logic c, input logic v, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        e.name = name;
        e.res  = res;
        e.z    = (res == 32'h0);
        e.q    = rst ? 32'h0 : last_res;
        e.zq   = rst ? 1'b0 : last_z;
        e.c    = c;
        e.v    = v;
        rst = r;
        bus.ALUControl = op;
        bus.A = a;
        bus.B = b;
        sb.push_back(e);
        last_res = e.res;
        last_z   = e.z;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, ".res"}, bus.ALUResult, e.res);
            check({e.name, ".zero"}, {31'b0, bus.Zero}, {31'b0, e.z});
            check({e.name, ".res_q"}, bus.ALUResult_q, e.q);
            check({e.name, ".zero_q"}, {31'b0, bus.Zero_q}, {31'b0, e.zq});
`ifdef ALU_FLAGS_EN
            check({e.name, ".carry"}, {31'b0, bus.Carry}, {31'b0, e.c});
            check({e.name, ".ovf"}, {31'b0, bus.Overflow}, {31'b0, e.v});
            check({e.name, ".neg"}, {31'b0, bus.Negative}, {31'b0, e.res[31]});
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.A = '0;
        bus.B = '0;
        bus.ALUControl = '0;
        apply(1, 4'b0000, 32'hFFFFFFFF, 32'h1,        32'h0,        1, 0, "add_wrap");
        apply(0, 4'b0001, 32'h5,        32'h5,        32'h0,        0, 0, "sub_eq");
        apply(0, 4'b0001, 32'h3,        32'h5,        32'hFFFFFFFE, 1, 0, "sub_neg");
        apply(0, 4'b0010, 32'h10000,    32'h10000,    32'h0,        0, 0, "mul_trunc");
        apply(0, 4'b0010, 32'hFFFFFFFF, 32'h3,        32'hFFFFFFFD, 0, 0, "mul_m1");
        apply(0, 4'b0111, 32'h1,        32'h1234,     32'hFFFFFFFF, 0, 0, "neg_1");
        apply(0, 4'b0111, 32'h80000000, 32'h0,        32'h80000000, 0, 1, "neg_min");
        apply(0, 4'b0110, 32'hFFFFFFFF, 32'h5,        32'h0,        0, 0, "not_ones");
        apply(0, 4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, "and");
        apply(0, 4'b0101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, "or");
        apply(0, 4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, "xor");
        apply(0, 4'b0000, 32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 1, "add_ovf");
        apply(0, 4'b0001, 32'h80000000, 32'h1,        32'h7FFFFFFF, 0, 1, "sub_ovf");
        apply(0, 4'b1000, 32'h80000001, 32'h1,        32'h00000002, 0, 0, "sll_1");
        apply(0, 4'b1010, 32'h80000001, 32'h1,        32'h00000002, 0, 0, "sla_1");
        apply(0, 4'b1000, 32'h80000001, 32'h1F,       32'h80000000, 0, 0, "sll_31");
        apply(0, 4'b1001, 32'h80000001, 32'h4,        32'h08000000, 0, 0, "srl_4");
        apply(0, 4'b1011, 32'h80000001, 32'h4,        32'hF8000000, 0, 0, "sra_4");
        apply(0, 4'b1011, 32'h80000001, 32'h24,       32'hF8000000, 0, 0, "sra_36");
        apply(0, 4'b1011, 32'h40000000, 32'h4,        32'h04000000, 0, 0, "sra_pos");
        apply(0, 4'b1001, 32'h80000001, 32'h20,       32'h80000001, 0, 0, "srl_32");
        apply(0, 4'b1100, 32'h80000001, 32'h1,        32'h00000003, 0, 0, "rol_1");
        apply(0, 4'b1101, 32'h80000001, 32'h1,        32'hC0000000, 0, 0, "ror_1");
        apply(0, 4'b1101, 32'h80000001, 32'h0,        32'h80000001, 0, 0, "ror_0");
        apply(0, 4'b1100, 32'h12345678, 32'h8,        32'h34567812, 0, 0, "rol_8");
        apply(0, 4'b1110, 32'h7,        32'h9,        32'h0,        0, 0, "undef_e");
        apply(0, 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        0, 0, "undef_f");
        apply(0, 4'b0000, 32'h2,        32'h3,        32'h5,        0, 0, "add_2_3");
        apply(1, 4'b0000, 32'h2,        32'h3,        32'h5,        0, 0, "rst_edge");
        apply(1, 4'b0000, 32'h2,        32'h3,        32'h5,        0, 0, "rst_held");
        apply(0, 4'b0001, 32'h9,        32'h2,        32'h7,        0, 0, "post_rst");
        apply(0, 4'b0000, 32'h0,        32'h0,        32'h0,        0, 0, "add_zero");
        repeat (2) @(posedge clk);
        #1;
        check("sb_drain", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
